// File: rtl/debounce_sync.sv
// Synchronises a raw asynchronous level into domain C, debounces it with a
// stability counter and emits a clean level plus one-cycle RISE/FALL pulses.
module debounce_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_WIDTH   = 4,
    parameter int unsigned STABLE_CNT  = 10,
    parameter bit          INIT_VAL    = 1'b0
) (
    input  logic C,
    input  logic CLR,
    input  logic D,
    output logic Q,
    output logic notQ,
    output logic RISE,
    output logic FALL,
    output logic BUSY
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CNT - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_q;
    logic                   s_d;

    state_e                 state_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic                   q_q;
    logic                   notq_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   busy_q;

    // Plain shift chain; nothing but the shift touches D or the stages.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            sync_q <= {SYNC_STAGES{INIT_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], D};
        end
    end

    // Qualification samples the final flop's input alongside that flop, so
    // Q lands on edge SYNC_STAGES+STABLE_CNT-1 after D settles.
    assign s_d = sync_q[SYNC_STAGES-2];
    assign s_q = sync_q[SYNC_STAGES-1];

    // Debounce FSM with registered outputs.
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            q_q     <= INIT_VAL;
            notq_q  <= ~INIT_VAL;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (s_d != q_q) begin
                        state_q <= COUNT;
                        cnt_q   <= CNT_WIDTH'(1);
                        busy_q  <= 1'b1;
                    end else begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                COUNT: begin
                    if (s_d == q_q) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        // s_q already carries the qualified value here.
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        q_q     <= s_q;
                        notq_q  <= ~s_q;
                        rise_q  <= s_q;
                        fall_q  <= ~s_q;
                    end else begin
                        cnt_q   <= cnt_q + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Q    = q_q;
    assign notQ = notq_q;
    assign RISE = rise_q;
    assign FALL = fall_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync: default instance plus a SYNC_STAGES=3,
// STABLE_CNT=2 instance, checked through an expectation queue.
module tb_debounce_sync;

    logic C = 1'b0;
    logic CLR;
    logic D;
    logic D2;
    logic Q, notQ, RISE, FALL, BUSY;
    logic Q2, notQ2, RISE2, FALL2, BUSY2;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string      tag;
        bit         sel2;
        logic [4:0] exp;   // {Q, notQ, RISE, FALL, BUSY}
    } exp_t;

    exp_t sb[$];

    always #5 C = ~C;

    debounce_sync dut (
        .C    (C),
        .CLR  (CLR),
        .D    (D),
        .Q    (Q),
        .notQ (notQ),
        .RISE (RISE),
        .FALL (FALL),
        .BUSY (BUSY)
    );

    debounce_sync #(
        .SYNC_STAGES (3),
        .CNT_WIDTH   (4),
        .STABLE_CNT  (2),
        .INIT_VAL    (1'b0)
    ) dut2 (
        .C    (C),
        .CLR  (CLR),
        .D    (D2),
        .Q    (Q2),
        .notQ (notQ2),
        .RISE (RISE2),
        .FALL (FALL2),
        .BUSY (BUSY2)
    );

    task automatic push(input string tag, input bit sel2, input logic q,
                        input logic rise, input logic fall, input logic busy);
        exp_t e;
        e.tag  = tag;
        e.sel2 = sel2;
        e.exp  = {q, ~q, rise, fall, busy};
        sb.push_back(e);
    endtask

    task automatic check_head();
        exp_t       e;
        logic [4:0] obs;
        e   = sb.pop_front();
        obs = e.sel2 ? {Q2, notQ2, RISE2, FALL2, BUSY2}
                     : {Q, notQ, RISE, FALL, BUSY};
        n_tests++;
        assert (obs === e.exp) else begin
            n_fail++;
            $error("FAIL %s: observed Q/notQ/RISE/FALL/BUSY=%b expected %b",
                   e.tag, obs, e.exp);
        end
    endtask

    // Expectation for the outputs just after the next rising edge.
    task automatic step(input string tag, input bit sel2, input logic q,
                        input logic rise, input logic fall, input logic busy);
        push(tag, sel2, q, rise, fall, busy);
        @(posedge C);
        #1;
        check_head();
    endtask

    // D settles before E1; BUSY after E2..E10, Q and pulse at E11, pulse gone at E12.
    task automatic qualify_default(input string tag, input logic nv);
        D = nv;
        step(tag, 1'b0, ~nv, 1'b0, 1'b0, 1'b0);
        for (int i = 2; i <= 10; i++) step(tag, 1'b0, ~nv, 1'b0, 1'b0, 1'b1);
        step(tag, 1'b0, nv, nv, ~nv, 1'b0);
        step(tag, 1'b0, nv, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        CLR = 1'b1;
        D   = 1'b1;
        D2  = 1'b0;
        #2;
        push("reset_async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_head();
        repeat (4) step("reset_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        D   = 1'b0;
        CLR = 1'b0;
        repeat (3) step("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        qualify_default("clean_rise", 1'b1);
        qualify_default("clean_fall", 1'b0);

        // Bounce: 1 for five cycles, 0 for two, then 1 steady.
        D = 1'b1;
        step("bounce", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) step("bounce", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        D = 1'b0;
        step("bounce", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("bounce_drop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        D = 1'b1;
        step("bounce_drop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (9) step("bounce_requal", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step("bounce_rise", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step("bounce_after", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

        // CLR between edges clears Q=1 without a clock edge.
        #2;
        CLR = 1'b1;
        #1;
        push("clr_async_q1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_head();
        repeat (2) step("clr_hold_d1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        CLR = 1'b0;
        qualify_default("release_d1_rise", 1'b1);
        qualify_default("fall_again", 1'b0);

        // Reset while cnt = 6.
        D = 1'b1;
        step("midcnt", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (6) step("midcnt", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        #2;
        CLR = 1'b1;
        #1;
        push("midcnt_clr", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_head();
        repeat (2) step("midcnt_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        CLR = 1'b0;
        qualify_default("midcnt_restart", 1'b1);

        // SYNC_STAGES=3, STABLE_CNT=2: Q on the 4th edge.
        D2 = 1'b1;
        step("p_rise", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("p_rise", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("p_rise", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        step("p_rise_e4", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("p_rise_after", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Single-cycle low glitch must not reach Q.
        D2 = 1'b0;
        step("p_glitch", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        D2 = 1'b1;
        step("p_glitch", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("p_glitch_busy", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (3) step("p_glitch_gone", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        D2 = 1'b0;
        step("p_fall", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("p_fall", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("p_fall", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step("p_fall_e4", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step("p_fall_after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
